// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues reads against a registered-read FIFO and
// streams the returned words out through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] pop_count
);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic             r_discard;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  logic [CNT_W-1:0] r_pop_count;

  logic             w_pop;
  logic             w_capture;
  logic [2:0]       w_level;
  logic             w_rd_en;

  assign w_pop     = (r_occ != 2'd0) && m_ready;
  assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight};
  // occ + inflight - pop < 2, rearranged to stay unsigned
  assign w_rd_en   = !rst && !flush && !fifo_empty &&
                     (w_level < (3'd2 + {2'b00, w_pop}));
  assign w_capture = r_inflight && !r_discard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_discard   <= 1'b0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_pop_count <= '0;
    end else begin
      r_pop_count <= r_pop_count + CNT_W'(w_pop);
      r_inflight  <= w_rd_en;
      r_discard   <= flush && r_inflight;
      if (flush) begin
        r_occ <= 2'd0;
      end else begin
        unique case ({w_pop, w_capture})
          2'b01: begin
            if (r_occ == 2'd0) r_buf0 <= fifo_data;
            else               r_buf1 <= fifo_data;
            r_occ <= r_occ + 2'd1;
          end
          2'b10: begin
            r_buf0 <= r_buf1;
            r_occ  <= r_occ - 2'd1;
          end
          2'b11: begin
            // head leaves while the new word enters the tail
            if (r_occ == 2'd1) begin
              r_buf0 <= fifo_data;
            end else begin
              r_buf0 <= r_buf1;
              r_buf1 <= fifo_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_buf0;
  assign busy       = (r_occ != 2'd0) || r_inflight;
  assign pop_count  = r_pop_count;

endmodule
